// File: rtl/spwm_pkg.sv
// spwm_pkg: shared types, widths, default parameters and duty arithmetic
// helpers for the sinusoidal PWM generator (spwm_gen).
// Optional feature macro used by the block: SPWM_SYNC_OUT_EN.
package spwm_pkg;

  // Default timing: 10000 clk per carrier gives a 5 kHz carrier at 50 MHz.
  localparam int CLK_PER_CARRIER_DEF = 10000;
  // Full-scale duty in clk cycles; must equal the carrier length so that
  // duty == DUTY_MAX means "high for the whole carrier".
  localparam int DUTY_MAX_DEF        = 10000;

  // Port widths.
  localparam int CICLOS_W = 11;
  localparam int DUTY_W   = 16;

  // Quarter-wave sequencer states. IDLE is the reset/parked state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RISE_P = 3'd1,
    FALL_P = 3'd2,
    RISE_N = 3'd3,
    FALL_N = 3'd4
  } state_t;

  // Rising step: duty + step, clamped to full scale. The sum is formed one
  // bit wider than the operands so a large step can never wrap around.
  function automatic logic [DUTY_W-1:0] duty_rise(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] step,
    input logic [DUTY_W:0]   full
  );
    logic [DUTY_W:0] sum;
    sum = {1'b0, duty} + {1'b0, step};
    if (sum > full) begin
      return full[DUTY_W-1:0];
    end
    return sum[DUTY_W-1:0];
  endfunction

  // Falling step: duty - step, floored at zero (equal values give zero).
  function automatic logic [DUTY_W-1:0] duty_fall(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] step
  );
    if (duty > step) begin
      return duty - step;
    end
    return '0;
  endfunction

  // Half-wave decode used for the output legs.
  function automatic logic is_pos_half(input state_t st);
    return (st == RISE_P) || (st == FALL_P);
  endfunction

  function automatic logic is_neg_half(input state_t st);
    return (st == RISE_N) || (st == FALL_N);
  endfunction

endpackage

// File: rtl/spwm_if.sv
// spwm_if: control inputs and PWM outputs of spwm_gen bundled as one bus.
// With SPWM_SYNC_OUT_EN defined the bus also carries the 1-clk sync strobe.
//
// Signalling: there is no valid/ready handshake on this bus. ciclos_pwm and
// cte are levels sampled every clk but only take effect when the generator
// latches them (leaving IDLE, or at the end of a full sine period). The
// outputs are plain registered levels, valid every clk after reset.
interface spwm_if;
  import spwm_pkg::*;

  logic [CICLOS_W-1:0] ciclos_pwm;  // carrier periods per quarter sine
  logic [DUTY_W-1:0]   cte;         // duty step per carrier, in clk
  logic                pwm_p;       // positive-half leg
  logic                pwm_n;       // negative-half leg
  logic                half_n;      // 1 during the negative half

`ifdef SPWM_SYNC_OUT_EN
  logic                sync;        // pulse at the start of each sine period

  modport master (
    output ciclos_pwm,
    output cte,
    input  pwm_p,
    input  pwm_n,
    input  half_n,
    input  sync
  );

  modport slave (
    input  ciclos_pwm,
    input  cte,
    output pwm_p,
    output pwm_n,
    output half_n,
    output sync
  );
`else
  modport master (
    output ciclos_pwm,
    output cte,
    input  pwm_p,
    input  pwm_n,
    input  half_n
  );

  modport slave (
    input  ciclos_pwm,
    input  cte,
    output pwm_p,
    output pwm_n,
    output half_n
  );
`endif

endinterface

// File: rtl/spwm_carrier.sv
// spwm_carrier: PWM carrier counter for spwm_gen. Counts
// 0..CLK_PER_CARRIER-1 while run_i is high and raises wrap_o on the last
// count of every carrier period. While run_i is low the count is parked at
// zero, so the first running clk always sees a count of 0.
module spwm_carrier
  import spwm_pkg::*;
#(
  parameter int CLK_PER_CARRIER = CLK_PER_CARRIER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  output logic [DUTY_W-1:0] cnt_o,
  output logic              wrap_o
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(CLK_PER_CARRIER - 1);
  localparam logic [DUTY_W-1:0] CNT_ONE  = DUTY_W'(1);

  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] cnt_d;
  logic              at_last_d;

  assign at_last_d = (cnt_q == CNT_LAST);

  // Next count: park at zero when stopped, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (at_last_d) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = run_i && at_last_d;

endmodule

// File: rtl/spwm_gen.sv
// spwm_gen: sinusoidal-approximation PWM generator. Each quarter of the
// output sine lasts ciclos_l carrier periods; the duty ramps up by cte_l per
// carrier in a RISE state and down by cte_l in a FALL state. The positive
// half drives pwm_p, the negative half drives pwm_n.
// Optional feature macro: SPWM_SYNC_OUT_EN adds bus.sync, a 1-clk strobe
// coincident with the first registered output clk of every RISE_P entry.
// state_o mirrors the sequencer state for observation.
module spwm_gen
  import spwm_pkg::*;
#(
  parameter int CLK_PER_CARRIER = CLK_PER_CARRIER_DEF,
  // Must equal CLK_PER_CARRIER: full-scale duty is a whole carrier.
  parameter int DUTY_MAX        = DUTY_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst,
  spwm_if.slave  bus,
  output state_t state_o
);

  localparam logic [DUTY_W:0]     DUTY_FULL  = (DUTY_W + 1)'(DUTY_MAX);
  localparam logic [CICLOS_W-1:0] CICLOS_ONE = CICLOS_W'(1);

  // Sequencer and datapath registers.
  state_t              state_q;
  logic [CICLOS_W-1:0] q_q;          // carrier wraps seen in this state
  logic [DUTY_W-1:0]   duty_q;       // high time of the current carrier
  logic [CICLOS_W-1:0] ciclos_l_q;   // latched quarter length
  logic [DUTY_W-1:0]   cte_l_q;      // latched duty step

  // Registered outputs.
  logic                pwm_p_q;
  logic                pwm_n_q;
  logic                half_n_q;
`ifdef SPWM_SYNC_OUT_EN
  logic                sync_q;
`endif

  // Carrier counter interface.
  logic                run_d;
  logic [DUTY_W-1:0]   cnt;
  logic                wrap;

  // Combinational helpers feeding the sequencer.
  logic                q_last_d;     // this wrap ends the quarter
  logic [DUTY_W-1:0]   duty_up_d;
  logic [DUTY_W-1:0]   duty_dn_d;
  logic                leg_on_d;     // count is inside the high time
  logic                pos_half_d;
  logic                neg_half_d;
  logic                new_ciclos_zero_d;

  assign run_d = (state_q != IDLE);

  spwm_carrier #(
    .CLK_PER_CARRIER (CLK_PER_CARRIER)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run_d),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  // ciclos_l_q is never zero outside IDLE, so ciclos_l_q - 1 cannot wrap
  // while it is used.
  assign q_last_d          = (q_q == (ciclos_l_q - CICLOS_ONE));
  assign duty_up_d         = duty_rise(duty_q, cte_l_q, DUTY_FULL);
  assign duty_dn_d         = duty_fall(duty_q, cte_l_q);
  assign leg_on_d          = (cnt < duty_q);
  assign pos_half_d        = is_pos_half(state_q);
  assign neg_half_d        = is_neg_half(state_q);
  assign new_ciclos_zero_d = (bus.ciclos_pwm == '0);

  // Quarter-wave sequencer, duty ramp and output registers in one process.
  // Outputs are computed from the state/count/duty of this clk and appear
  // one clk later. A duty of 0 never satisfies cnt < duty (leg low); a duty
  // of DUTY_MAX is above every count (leg high for the whole carrier).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      q_q        <= '0;
      duty_q     <= '0;
      ciclos_l_q <= '0;
      cte_l_q    <= '0;
      pwm_p_q    <= 1'b0;
      pwm_n_q    <= 1'b0;
      half_n_q   <= 1'b0;
`ifdef SPWM_SYNC_OUT_EN
      sync_q     <= 1'b0;
`endif
    end else begin
      pwm_p_q  <= pos_half_d && leg_on_d;
      pwm_n_q  <= neg_half_d && leg_on_d;
      half_n_q <= neg_half_d;
`ifdef SPWM_SYNC_OUT_EN
      // First clk of a RISE_P state: first carrier, count zero.
      sync_q   <= (state_q == RISE_P) && (q_q == '0) && (cnt == '0);
`endif

      case (state_q)
        IDLE: begin
          q_q    <= '0;
          duty_q <= '0;
          if (!new_ciclos_zero_d) begin
            ciclos_l_q <= bus.ciclos_pwm;
            cte_l_q    <= bus.cte;
            state_q    <= RISE_P;
          end
        end

        RISE_P, RISE_N: begin
          if (wrap) begin
            // The ramp step also applies on the last wrap, so the first
            // FALL carrier starts one step above the last RISE carrier.
            duty_q <= duty_up_d;
            if (q_last_d) begin
              q_q     <= '0;
              state_q <= (state_q == RISE_P) ? FALL_P : FALL_N;
            end else begin
              q_q <= q_q + CICLOS_ONE;
            end
          end
        end

        FALL_P: begin
          if (wrap) begin
            if (q_last_d) begin
              q_q     <= '0;
              duty_q  <= '0;
              state_q <= RISE_N;
            end else begin
              q_q    <= q_q + CICLOS_ONE;
              duty_q <= duty_dn_d;
            end
          end
        end

        FALL_N: begin
          if (wrap) begin
            if (q_last_d) begin
              // End of a full sine period: the only place new settings are
              // picked up while running. A zero quarter length parks us.
              q_q        <= '0;
              duty_q     <= '0;
              ciclos_l_q <= bus.ciclos_pwm;
              cte_l_q    <= bus.cte;
              state_q    <= new_ciclos_zero_d ? IDLE : RISE_P;
            end else begin
              q_q    <= q_q + CICLOS_ONE;
              duty_q <= duty_dn_d;
            end
          end
        end

        default: begin
          q_q     <= '0;
          duty_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pwm_p  = pwm_p_q;
  assign bus.pwm_n  = pwm_n_q;
  assign bus.half_n = half_n_q;
`ifdef SPWM_SYNC_OUT_EN
  assign bus.sync   = sync_q;
`endif
  assign state_o    = state_q;

endmodule

// File: doc/spwm_gen.md
SPWM_GEN -- requirements
Module: spwm_gen

Interface
REQ-001 Parameter CLK_PER_CARRIER, default 10000: clk cycles per PWM carrier period (5 kHz at 50 MHz).
REQ-002 Parameter DUTY_MAX, default 10000: full-scale duty in clk cycles; SHALL equal CLK_PER_CARRIER.
REQ-003 Port clk  input  1  system clock, 50 MHz.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port ciclos_pwm  input  11  carrier periods per quarter of the output sine period.
REQ-006 Port cte  input  16  duty increment or decrement per carrier period, in clk cycles.
REQ-007 Port pwm_p  output  1  positive-half PWM leg, registered.
REQ-008 Port pwm_n  output  1  negative-half PWM leg, registered.
REQ-009 Port half_n  output  1  0 during the positive half, 1 during the negative half.

Function
REQ-010 The block SHALL contain a carrier counter cnt counting 0..CLK_PER_CARRIER-1 and wrapping to 0; a wrap SHALL occur when cnt==CLK_PER_CARRIER-1.
REQ-011 The FSM SHALL have states IDLE, RISE_P, FALL_P, RISE_N and FALL_N.
REQ-012 In IDLE, cnt, q and duty SHALL be held at 0 and all outputs SHALL be 0.
REQ-013 In IDLE, when ciclos_pwm!=0, the block SHALL latch ciclos_pwm and cte into ciclos_l and cte_l and enter RISE_P on the next clk, with cnt=0 and duty=0.
REQ-014 ciclos_l and cte_l SHALL change only at IDLE exit or at the FALL_N to RISE_P boundary; input changes mid-period SHALL have no effect until that boundary.
REQ-015 A quarter counter q SHALL count carrier wraps 0..ciclos_l-1 within each state.
REQ-016 At a wrap with q==ciclos_l-1, the FSM SHALL advance RISE_P to FALL_P to RISE_N to FALL_N to RISE_P, and q SHALL return to 0.
REQ-017 At each wrap in a RISE state, duty SHALL become min(duty+cte_l, DUTY_MAX), computed 17 bits wide with no overflow; this SHALL also apply on the RISE to FALL transition.
REQ-018 At each wrap in a FALL state, duty SHALL become duty-cte_l if duty>cte_l, and 0 otherwise.
REQ-019 On any FALL to RISE transition, duty SHALL be forced to 0.
REQ-020 In the clk after a count value c, pwm_p SHALL be high iff the state is RISE_P or FALL_P and c<duty; pwm_n SHALL be high under the same rule for RISE_N or FALL_N; this is a 1-clk registered latency.
REQ-021 pwm_p and pwm_n SHALL never be high in the same clk.
REQ-022 duty==0 SHALL give a constant-low leg and duty==DUTY_MAX SHALL give a constant-high leg for that carrier period.
REQ-023 half_n SHALL be 1 iff the state is RISE_N or FALL_N, registered with the same latency as the PWM outputs.
REQ-024 At the FALL_N end, if the newly latched ciclos_pwm==0, the FSM SHALL go to IDLE instead of RISE_P.
REQ-025 cte==0 SHALL be legal and SHALL give duty=0 throughout, with outputs low but the FSM still sequencing.

Reset
REQ-026 With rst high at a clk edge, the block SHALL set state=IDLE, cnt=0, q=0, duty=0, ciclos_l=0, cte_l=0, pwm_p=0, pwm_n=0, half_n=0 and, if compiled in, sync=0.
REQ-027 Reset asserted mid-period SHALL abort the current period; the first clk after rst deasserts SHALL be evaluated as IDLE.

Configuration
REQ-028 With macro SPWM_SYNC_OUT_EN defined, the block SHALL add output port sync (1 bit), pulsed high for exactly 1 clk coincident with the first registered output clk of every RISE_P entry.
REQ-029 Without SPWM_SYNC_OUT_EN, the sync port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package spwm_pkg SHALL hold the FSM state enum, CLK_PER_CARRIER and DUTY_MAX defaults, and the width constants (11 for ciclos, 16 for cte/duty).
REQ-031 The carrier counter with its wrap strobe SHALL be a sub-module named spwm_carrier; the FSM, duty arithmetic and output registers SHALL reside in spwm_gen.

Verification
REQ-032 Scenario: ciclos_pwm=4, cte=2500 -> per-carrier pwm_p high counts 0,2500,5000,7500 then 10000,7500,5000,2500; pwm_n repeats the same pattern; the sequence repeats every 16 carriers.
REQ-033 Scenario: ciclos_pwm=3, cte=4000 -> RISE duty 0,4000,8000 and FALL starts at 10000 (saturated), then 6000,2000; RISE_N restarts at 0.
REQ-034 Scenario: change cte from 2500 to 1250 mid-RISE_P -> no effect until the next RISE_P, then rising duties 0,1250,2500,3750.
REQ-035 Scenario: ciclos_pwm forced to 0 during FALL_P -> the period completes, then IDLE with outputs 0; ciclos_pwm=2 then restarts in RISE_P within 1 clk.
REQ-036 Scenario: rst pulsed for 1 clk in RISE_N -> all outputs 0 the next clk, state IDLE, and a clean restart at pwm_p duty 0.
REQ-037 Scenario: with SPWM_SYNC_OUT_EN and ciclos_pwm=1 -> sync pulses once every 4 carriers (40000 clk), 1 clk wide, and pwm_p and pwm_n are never high together.
